// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UTXD1B serial transmitter among N_REQ byte sources in
// round-robin order. UTXD1B reports neither busy nor done, so this block times each frame
// (plus an idle gap) on its own before it grants the next source.
//
// Ports
//   clk       system clock
//   rst       synchronous reset, active-high
//   req       level request per source, bit i = source i
//   dat_in    byte of source i on dat_in[8*i+7:8*i]
//   ack       one-cycle pulse: byte of source i accepted
//   tx_dat    byte to UTXD1B, stable from ack until frame end
//   tx_st     one-cycle start pulse to UTXD1B
//   busy      high while a frame or the post-reset guard is in progress
//   grant_id  index of the source currently or last served
module uart_tx_arbiter #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned BIT_CYC    = 434,
  parameter int unsigned FRAME_BITS = 10,
  parameter int unsigned GAP_BITS   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [8*N_REQ-1:0]         dat_in,
  output logic [N_REQ-1:0]           ack,
  output logic [7:0]                 tx_dat,
  output logic                       tx_st,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   grant_id
);

  localparam int unsigned FRAME_CYC = BIT_CYC * (FRAME_BITS + GAP_BITS);
  localparam int unsigned GW        = $clog2(N_REQ);
  localparam int unsigned CW        = $clog2(FRAME_CYC);
  localparam logic [CW-1:0] CntMax  = CW'(FRAME_CYC - 1);

  typedef enum logic [1:0] {StGuard, StIdle, StStart, StWait} state_e;

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [GW-1:0]     ptr_q;
  logic [GW-1:0]     grant_q;
  logic [N_REQ-1:0]  ack_q;
  logic [7:0]        tx_dat_q;
  logic              tx_st_q;
  logic              busy_q;

  // Per-source byte view of the flat data bus.
  logic [7:0] dat_arr [N_REQ];
  for (genvar g = 0; g < N_REQ; g++) begin : g_dat
    assign dat_arr[g] = dat_in[8*g +: 8];
  end

  // Winner: first requesting source at or after ptr, searching cyclically.
  logic [GW-1:0] win;
  logic          win_vld;
  logic [GW-1:0] cand;
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    cand    = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = GW'((32'(ptr_q) + i) % N_REQ);
      if (!win_vld && req[cand]) begin
        win     = cand;
        win_vld = 1'b1;
      end
    end
  end

  logic [GW-1:0] ptr_next;
  assign ptr_next = (grant_q == GW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      // UTXD1B has no reset and may still be shifting out a frame: wait one full frame.
      state_q  <= StGuard;
      cnt_q    <= CntMax;
      ptr_q    <= '0;
      grant_q  <= '0;
      ack_q    <= '0;
      tx_dat_q <= '0;
      tx_st_q  <= 1'b0;
      busy_q   <= 1'b1;
    end else begin
      ack_q   <= '0;
      tx_st_q <= 1'b0;
      unique case (state_q)
        StGuard: begin
          if (cnt_q == '0) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StIdle: begin
          if (win_vld) begin
            tx_dat_q   <= dat_arr[win];
            grant_q    <= win;
            ack_q[win] <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= StStart;
          end else begin
            busy_q <= 1'b0;
          end
        end
        StStart: begin
          tx_st_q <= 1'b1;
          cnt_q   <= CntMax;
          state_q <= StWait;
        end
        StWait: begin
          if (cnt_q == '0) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            ptr_q   <= ptr_next;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= StGuard;
      endcase
    end
  end

  assign ack      = ack_q;
  assign tx_dat   = tx_dat_q;
  assign tx_st    = tx_st_q;
  assign busy     = busy_q;
  assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int unsigned NR  = 4;
  localparam int unsigned BC  = 4;
  localparam int unsigned FB  = 10;
  localparam int unsigned GB  = 1;
  localparam int unsigned FC  = BC * (FB + GB);  // 44
  localparam int unsigned PER = FC + 2;          // 46

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] req = '0;
  logic [31:0]   dat_in = '0;
  logic [NR-1:0] ack;
  logic [7:0]    tx_dat;
  logic          tx_st;
  logic          busy;
  logic [1:0]    grant_id;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] dat;
  } exp_t;
  exp_t sb[$];

  uart_tx_arbiter #(
    .N_REQ     (NR),
    .BIT_CYC   (BC),
    .FRAME_BITS(FB),
    .GAP_BITS  (GB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .dat_in  (dat_in),
    .ack     (ack),
    .tx_dat  (tx_dat),
    .tx_st   (tx_st),
    .busy    (busy),
    .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until an ack is seen or max edges elapse; n is the number of edges taken.
  task automatic wait_ack(input int max, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (ack == '0 && n < max);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 500) begin
      step();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_timeout busy=%b required 0", busy);
    end
  endtask

  task automatic take(output exp_t e, output bit have);
    have = (sb.size() > 0);
    e    = have ? sb.pop_front() : '0;
  endtask

  task automatic test_reset();
    int   bad;
    exp_t e;
    bit   have;
    rst    = 1'b1;
    req    = 4'b1111;
    dat_in = 32'h4433_2211;
    step();
    step();
    checks++;
    if (ack !== 4'b0 || tx_st !== 1'b0 || tx_dat !== 8'h00 || grant_id !== 2'd0 || busy !== 1'b1)
    begin
      failures++;
      $display("FAIL reset_values ack=%b tx_st=%b tx_dat=%h grant_id=%0d busy=%b required 0000 0 00 0 1",
               ack, tx_st, tx_dat, grant_id, busy);
    end
    rst = 1'b0;
    sb.push_back('{id: 2'd0, dat: 8'h11});
    bad = 0;
    for (int i = 1; i <= 43; i++) begin
      step();
      if (busy !== 1'b1 || ack !== 4'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL reset_guard bad_cycles=%0d required 0", bad);
    end
    step();
    checks++;
    if (busy !== 1'b0 || ack !== 4'b0) begin
      failures++;
      $display("FAIL guard_end busy=%b ack=%b required 0 0000", busy, ack);
    end
    step();
    take(e, have);
    checks++;
    if (!have || ack !== (4'b0001 << e.id) || tx_dat !== e.dat || grant_id !== e.id || busy !== 1'b1)
    begin
      failures++;
      $display("FAIL first_grant ack=%b tx_dat=%h grant_id=%0d busy=%b required id=%0d dat=%h busy=1",
               ack, tx_dat, grant_id, busy, e.id, e.dat);
    end
    req = 4'b0;
    step();
    checks++;
    if (tx_st !== 1'b1 || ack !== 4'b0) begin
      failures++;
      $display("FAIL first_tx_st tx_st=%b ack=%b required 1 0000", tx_st, ack);
    end
    step();
    checks++;
    if (tx_st !== 1'b0) begin
      failures++;
      $display("FAIL first_tx_st_width tx_st=%b required 0", tx_st);
    end
    wait_idle();
  endtask

  task automatic test_single();
    int   n, hi, pulses, dat_bad;
    exp_t e;
    bit   have;
    dat_in[15:8] = 8'hA7;
    req          = 4'b0010;
    sb.push_back('{id: 2'd1, dat: 8'hA7});
    wait_ack(5, n);
    take(e, have);
    checks++;
    if (n != 1 || !have || ack !== (4'b0001 << e.id) || tx_dat !== e.dat || grant_id !== e.id) begin
      failures++;
      $display("FAIL single_grant lat=%0d ack=%b tx_dat=%h grant_id=%0d required lat=1 id=%0d dat=%h",
               n, ack, tx_dat, grant_id, e.id, e.dat);
    end
    req          = 4'b0;
    dat_in[15:8] = 8'h5A;
    hi           = (busy === 1'b1) ? 1 : 0;
    step();
    checks++;
    if (tx_st !== 1'b1 || ack !== 4'b0) begin
      failures++;
      $display("FAIL single_tx_st tx_st=%b ack=%b required 1 0000", tx_st, ack);
    end
    if (busy === 1'b1) hi++;
    pulses  = 0;
    dat_bad = 0;
    n       = 0;
    while (busy === 1'b1 && n < 200) begin
      step();
      n++;
      if (busy === 1'b1) hi++;
      if (tx_st !== 1'b0) pulses++;
      if (tx_dat !== 8'hA7 && busy === 1'b1) dat_bad++;
    end
    checks++;
    if (hi != FC + 1) begin
      failures++;
      $display("FAIL single_busy_len busy_cycles=%0d required %0d", hi, FC + 1);
    end
    checks++;
    if (pulses != 0 || dat_bad != 0) begin
      failures++;
      $display("FAIL single_hold extra_tx_st=%0d tx_dat_changes=%0d required 0 0", pulses, dat_bad);
    end
  endtask

  // Serves count acks in a row, checking each against the scoreboard and the fixed period.
  task automatic serve_run(input string name, input int count, input logic [3:0] req_after);
    int   n;
    exp_t e;
    bit   have;
    for (int j = 0; j < count; j++) begin
      wait_ack((j == 0) ? 5 : 200, n);
      take(e, have);
      checks++;
      if (!have || ack !== (4'b0001 << e.id) || tx_dat !== e.dat || grant_id !== e.id ||
          n != ((j == 0) ? 1 : PER - 1)) begin
        failures++;
        $display("FAIL %s_grant%0d ack=%b tx_dat=%h grant_id=%0d gap=%0d required id=%0d dat=%h gap=%0d",
                 name, j, ack, tx_dat, grant_id, n, e.id, e.dat, (j == 0) ? 1 : PER - 1);
      end
      if (j == count - 1) req = req_after;
      step();
      checks++;
      if (tx_st !== 1'b1 || ack !== 4'b0) begin
        failures++;
        $display("FAIL %s_tx_st%0d tx_st=%b ack=%b required 1 0000", name, j, tx_st, ack);
      end
    end
  endtask

  task automatic test_back_to_back();
    // Previous grant was source 1, so the rotation starts at source 2.
    dat_in = 32'h4433_2211;
    req    = 4'b1111;
    sb.push_back('{id: 2'd2, dat: 8'h33});
    sb.push_back('{id: 2'd3, dat: 8'h44});
    sb.push_back('{id: 2'd0, dat: 8'h11});
    sb.push_back('{id: 2'd1, dat: 8'h22});
    sb.push_back('{id: 2'd2, dat: 8'h33});
    serve_run("b2b", 5, 4'b1101);
  endtask

  task automatic test_fairness();
    int   n;
    exp_t e;
    bit   have;
    // Last grant was 2 and it still requests: 3 and 0 must be served before 2 again.
    sb.push_back('{id: 2'd3, dat: 8'h44});
    sb.push_back('{id: 2'd0, dat: 8'h11});
    sb.push_back('{id: 2'd2, dat: 8'h33});
    for (int j = 0; j < 3; j++) begin
      wait_ack(200, n);
      take(e, have);
      checks++;
      if (!have || ack !== (4'b0001 << e.id) || tx_dat !== e.dat || n != PER - 1) begin
        failures++;
        $display("FAIL fair_grant%0d ack=%b tx_dat=%h gap=%0d required id=%0d dat=%h gap=%0d",
                 j, ack, tx_dat, n, e.id, e.dat, PER - 1);
      end
      if (j == 2) req = 4'b0;
      step();
    end
    wait_idle();
  endtask

  task automatic test_drop();
    int   n, extra;
    exp_t e;
    bit   have;
    req = 4'b0001;
    sb.push_back('{id: 2'd0, dat: 8'h11});
    wait_ack(5, n);
    take(e, have);
    checks++;
    if (n != 1 || !have || ack !== (4'b0001 << e.id) || tx_dat !== e.dat) begin
      failures++;
      $display("FAIL drop_first lat=%0d ack=%b tx_dat=%h required lat=1 id=%0d dat=%h",
               n, ack, tx_dat, e.id, e.dat);
    end
    req = 4'b0;
    step();
    repeat (10) step();
    req = 4'b0100;
    repeat (5) step();
    req   = 4'b0;
    extra = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (ack !== 4'b0 || tx_st !== 1'b0) extra++;
    end
    checks++;
    if (extra != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL drop_no_grant stray_cycles=%0d busy=%b required 0 0", extra, busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    int   n;
    exp_t e;
    bit   have;
    req = 4'b0100;
    sb.push_back('{id: 2'd2, dat: 8'h33});
    wait_ack(5, n);
    take(e, have);
    checks++;
    if (n != 1 || !have || ack !== (4'b0001 << e.id) || tx_dat !== e.dat) begin
      failures++;
      $display("FAIL midrst_first lat=%0d ack=%b tx_dat=%h required lat=1 id=%0d dat=%h",
               n, ack, tx_dat, e.id, e.dat);
    end
    req = 4'b0;
    step();
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (tx_st !== 1'b0 || ack !== 4'b0 || busy !== 1'b1 || grant_id !== 2'd0 || tx_dat !== 8'h00)
    begin
      failures++;
      $display("FAIL midrst_values tx_st=%b ack=%b busy=%b grant_id=%0d tx_dat=%h required 0 0000 1 0 00",
               tx_st, ack, busy, grant_id, tx_dat);
    end
    // Pointer is back at 0, so source 0 wins over 2; grant lands one edge after the guard.
    req = 4'b0101;
    sb.push_back('{id: 2'd0, dat: 8'h11});
    wait_ack(200, n);
    take(e, have);
    checks++;
    if (n != FC + 1 || !have || ack !== (4'b0001 << e.id) || tx_dat !== e.dat) begin
      failures++;
      $display("FAIL midrst_regrant lat=%0d ack=%b tx_dat=%h required lat=%0d id=%0d dat=%h",
               n, ack, tx_dat, FC + 1, e.id, e.dat);
    end
    req = 4'b0;
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fairness();
    test_drop();
    test_reset_mid_frame();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_left entries=%0d required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
